reg_status_ctrl: RTL and testbench

Register status controller that sequences access to the architectural register file in the out-of-order core. It tracks, for each of the 32 registers, whether an in-flight ROB entry will write it and which ROB tag that is. It answers issue-stage operand lookups and funnels ROB commits into the single register-file write port. It sits between decode/issue, the ROB commit port and `regfile`, and is the only block that drives the regfile write controls.

---
 rtl/reg_status_ctrl.sv | 153 +++++++++++++++
 tb/tb_reg_status_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_status_ctrl.sv
// Register status controller: per-register busy/tag scoreboard, issue-time operand lookup
// with same-cycle commit forwarding, and the single regfile write port driven from ROB commits.
module reg_status_ctrl #(
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [4:0]       issue_rs1,
  input  logic [4:0]       issue_rs2,
  input  logic [4:0]       issue_rd,
  input  logic             issue_rd_we,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             lk_valid,
  output logic             lk_rs1_busy,
  output logic             lk_rs2_busy,
  output logic [TAG_W-1:0] lk_rs1_tag,
  output logic [TAG_W-1:0] lk_rs2_tag,
  output logic             lk_rs1_fwd,
  output logic             lk_rs2_fwd,
  output logic [31:0]      lk_fwd_data1,
  output logic [31:0]      lk_fwd_data2,
  input  logic             commit_valid,
  input  logic [4:0]       commit_rd,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic [31:0]      commit_data,
  input  logic             flush,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [5:0]       busy_count
);

  typedef enum logic {RUN, DRAIN} mode_e;

  mode_e                     mode_q, mode_d;
  logic [31:0]               busy_q, busy_d;
  logic [31:0][TAG_W-1:0]    tag_q, tag_d;
  logic [5:0]                busy_count_q, busy_count_d;
  logic                      lk_valid_q, lk_valid_d;
  logic [1:0]                lk_busy_q, lk_busy_d;
  logic [1:0]                lk_fwd_q, lk_fwd_d;
  logic [1:0][TAG_W-1:0]     lk_tag_q, lk_tag_d;
  logic [1:0][31:0]          lk_data_q, lk_data_d;
  logic                      rf_we_q, rf_we_d;
  logic [4:0]                rf_waddr_q, rf_waddr_d;
  logic [31:0]               rf_wdata_q, rf_wdata_d;

  logic                      issue_acc;
  logic                      cmt_act;
  logic [1:0][4:0]           src;

  assign src       = {issue_rs2, issue_rs1};
  assign issue_acc = issue_valid && (mode_q == RUN) && !flush;
  assign cmt_act   = commit_valid && (commit_rd != 5'd0);

  always_comb begin
    mode_d       = mode_q;
    busy_d       = busy_q;
    tag_d        = tag_q;
    busy_count_d = '0;
    lk_valid_d   = issue_acc;
    lk_busy_d    = '0;
    lk_fwd_d     = '0;
    lk_tag_d     = '0;
    lk_data_d    = '0;
    rf_we_d      = cmt_act;
    rf_waddr_d   = cmt_act ? commit_rd : 5'd0;
    rf_wdata_d   = cmt_act ? commit_data : 32'd0;

    if (flush) begin
      mode_d = DRAIN;
    end else if (mode_q == DRAIN) begin
      mode_d = RUN;
    end

    // Lookups see the table before this issue's own rd update; a matching commit forwards.
    for (int s = 0; s < 2; s++) begin
      if (issue_acc && (src[s] != 5'd0) && busy_q[src[s]]) begin
        if (cmt_act && (commit_rd == src[s]) && (tag_q[src[s]] == commit_tag)) begin
          lk_fwd_d[s]  = 1'b1;
          lk_data_d[s] = commit_data;
        end else begin
          lk_busy_d[s] = 1'b1;
          lk_tag_d[s]  = tag_q[src[s]];
        end
      end
    end

    // Commit clears only when it retires the current producer; the issue update wins after it.
    if (cmt_act && (tag_q[commit_rd] == commit_tag)) begin
      busy_d[commit_rd] = 1'b0;
    end
    if (issue_acc && issue_rd_we && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
      tag_d[issue_rd]  = issue_tag;
    end
    if (flush) begin
      busy_d = '0;
    end

    for (int i = 0; i < 32; i++) begin
      busy_count_d = busy_count_d + 6'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q       <= DRAIN;
      busy_q       <= '0;
      tag_q        <= '0;
      busy_count_q <= '0;
      lk_valid_q   <= 1'b0;
      lk_busy_q    <= '0;
      lk_fwd_q     <= '0;
      lk_tag_q     <= '0;
      lk_data_q    <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      mode_q       <= mode_d;
      busy_q       <= busy_d;
      tag_q        <= tag_d;
      busy_count_q <= busy_count_d;
      lk_valid_q   <= lk_valid_d;
      lk_busy_q    <= lk_busy_d;
      lk_fwd_q     <= lk_fwd_d;
      lk_tag_q     <= lk_tag_d;
      lk_data_q    <= lk_data_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign issue_ready  = (mode_q == RUN);
  assign lk_valid     = lk_valid_q;
  assign lk_rs1_busy  = lk_busy_q[0];
  assign lk_rs2_busy  = lk_busy_q[1];
  assign lk_rs1_tag   = lk_tag_q[0];
  assign lk_rs2_tag   = lk_tag_q[1];
  assign lk_rs1_fwd   = lk_fwd_q[0];
  assign lk_rs2_fwd   = lk_fwd_q[1];
  assign lk_fwd_data1 = lk_data_q[0];
  assign lk_fwd_data2 = lk_data_q[1];
  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign busy_count   = busy_count_q;

endmodule

// File: tb/tb_reg_status_ctrl.sv
// Bench for reg_status_ctrl: table of per-cycle stimulus with hand-derived expected outputs,
// queued at drive time and compared one cycle later, plus reset corner sequences.
module tb_reg_status_ctrl;

  localparam int TAG_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid, issue_ready, issue_rd_we;
  logic [4:0]       issue_rs1, issue_rs2, issue_rd;
  logic [TAG_W-1:0] issue_tag;
  logic             lk_valid, lk_rs1_busy, lk_rs2_busy, lk_rs1_fwd, lk_rs2_fwd;
  logic [TAG_W-1:0] lk_rs1_tag, lk_rs2_tag;
  logic [31:0]      lk_fwd_data1, lk_fwd_data2;
  logic             commit_valid, flush, rf_we;
  logic [4:0]       commit_rd, rf_waddr;
  logic [TAG_W-1:0] commit_tag;
  logic [31:0]      commit_data, rf_wdata;
  logic [5:0]       busy_count;

  reg_status_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_rd_we(issue_rd_we), .issue_tag(issue_tag),
    .lk_valid(lk_valid), .lk_rs1_busy(lk_rs1_busy), .lk_rs2_busy(lk_rs2_busy),
    .lk_rs1_tag(lk_rs1_tag), .lk_rs2_tag(lk_rs2_tag),
    .lk_rs1_fwd(lk_rs1_fwd), .lk_rs2_fwd(lk_rs2_fwd),
    .lk_fwd_data1(lk_fwd_data1), .lk_fwd_data2(lk_fwd_data2),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_data(commit_data), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             iv;
    logic [4:0]       rs1, rs2, rd;
    logic             we;
    logic [TAG_W-1:0] itag;
    logic             cv;
    logic [4:0]       crd;
    logic [TAG_W-1:0] ctag;
    logic [31:0]      cdata;
    logic             fl;
  } in_t;

  typedef struct {
    logic             lkv, b1;
    logic [TAG_W-1:0] t1;
    logic             f1;
    logic [31:0]      d1;
    logic             b2;
    logic [TAG_W-1:0] t2;
    logic             f2;
    logic [31:0]      d2;
    logic             we;
    logic [4:0]       waddr;
    logic [31:0]      wdata;
    logic [5:0]       cnt;
    logic             rdy;
  } ex_t;

  typedef struct {
    in_t i;
    ex_t e;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];
  ex_t  expq [$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_rd_we = 0; issue_tag = 0;
    commit_valid = 0; commit_rd = 0; commit_tag = 0; commit_data = 0; flush = 0;
  endtask

  task automatic drive(input in_t v);
    issue_valid = v.iv; issue_rs1 = v.rs1; issue_rs2 = v.rs2; issue_rd = v.rd;
    issue_rd_we = v.we; issue_tag = v.itag;
    commit_valid = v.cv; commit_rd = v.crd; commit_tag = v.ctag; commit_data = v.cdata;
    flush = v.fl;
  endtask

  task automatic check_all(input string p, input ex_t e);
    chk({p, ".lk_valid"}, 32'(lk_valid), 32'(e.lkv));
    chk({p, ".rs1_busy"}, 32'(lk_rs1_busy), 32'(e.b1));
    chk({p, ".rs1_tag"}, 32'(lk_rs1_tag), 32'(e.t1));
    chk({p, ".rs1_fwd"}, 32'(lk_rs1_fwd), 32'(e.f1));
    chk({p, ".fwd_data1"}, lk_fwd_data1, e.d1);
    chk({p, ".rs2_busy"}, 32'(lk_rs2_busy), 32'(e.b2));
    chk({p, ".rs2_tag"}, 32'(lk_rs2_tag), 32'(e.t2));
    chk({p, ".rs2_fwd"}, 32'(lk_rs2_fwd), 32'(e.f2));
    chk({p, ".fwd_data2"}, lk_fwd_data2, e.d2);
    chk({p, ".rf_we"}, 32'(rf_we), 32'(e.we));
    chk({p, ".rf_waddr"}, 32'(rf_waddr), 32'(e.waddr));
    chk({p, ".rf_wdata"}, rf_wdata, e.wdata);
    chk({p, ".busy_count"}, 32'(busy_count), 32'(e.cnt));
    chk({p, ".issue_ready"}, 32'(issue_ready), 32'(e.rdy));
  endtask

  ex_t zero_e;

  initial begin
    // in : iv rs1 rs2 rd we itag cv crd ctag cdata fl
    // ex : lkv b1 t1 f1 d1 b2 t2 f2 d2 we waddr wdata cnt rdy
    tbl[0]  = '{'{0,0,0,0,0,0, 0,0,0,0,0},           '{0,0,0,0,0,0,0,0,0, 0,0,0, 0,1}};
    tbl[1]  = '{'{1,0,0,5,1,3, 0,0,0,0,0},           '{1,0,0,0,0,0,0,0,0, 0,0,0, 1,1}};
    tbl[2]  = '{'{1,5,6,6,1,2, 0,0,0,0,0},           '{1,1,3,0,0,0,0,0,0, 0,0,0, 2,1}};
    tbl[3]  = '{'{0,0,0,0,0,0, 1,5,3,'h1234,0},      '{0,0,0,0,0,0,0,0,0, 1,5,'h1234, 1,1}};
    tbl[4]  = '{'{1,5,6,0,0,0, 0,0,0,0,0},           '{1,0,0,0,0,1,2,0,0, 0,0,0, 1,1}};
    tbl[5]  = '{'{1,0,0,5,1,3, 0,0,0,0,0},           '{1,0,0,0,0,0,0,0,0, 0,0,0, 2,1}};
    tbl[6]  = '{'{1,5,0,5,1,6, 0,0,0,0,0},           '{1,1,3,0,0,0,0,0,0, 0,0,0, 2,1}};
    tbl[7]  = '{'{1,5,0,0,0,0, 1,5,3,'hAAAA,0},      '{1,1,6,0,0,0,0,0,0, 1,5,'hAAAA, 2,1}};
    tbl[8]  = '{'{1,0,0,7,1,2, 0,0,0,0,0},           '{1,0,0,0,0,0,0,0,0, 0,0,0, 3,1}};
    tbl[9]  = '{'{1,6,7,0,0,0, 1,7,2,'hBEEF,0},      '{1,1,2,0,0,0,0,1,'hBEEF, 1,7,'hBEEF, 2,1}};
    tbl[10] = '{'{1,0,0,6,1,4, 1,6,2,'h55,0},        '{1,0,0,0,0,0,0,0,0, 1,6,'h55, 2,1}};
    tbl[11] = '{'{1,6,0,0,0,0, 0,0,0,0,0},           '{1,1,4,0,0,0,0,0,0, 0,0,0, 2,1}};
    tbl[12] = '{'{1,0,0,8,1,5, 0,0,0,0,0},           '{1,0,0,0,0,0,0,0,0, 0,0,0, 3,1}};
    tbl[13] = '{'{1,0,0,9,1,1, 0,0,0,0,0},           '{1,0,0,0,0,0,0,0,0, 0,0,0, 4,1}};
    tbl[14] = '{'{1,5,0,10,1,7, 1,9,1,'h99,1},       '{0,0,0,0,0,0,0,0,0, 1,9,'h99, 0,0}};
    tbl[15] = '{'{0,0,0,0,0,0, 0,0,0,0,1},           '{0,0,0,0,0,0,0,0,0, 0,0,0, 0,0}};
    tbl[16] = '{'{1,0,0,12,1,3, 1,4,0,'h44,0},       '{0,0,0,0,0,0,0,0,0, 1,4,'h44, 0,1}};
    tbl[17] = '{'{1,0,0,11,1,1, 0,0,0,0,0},          '{1,0,0,0,0,0,0,0,0, 0,0,0, 1,1}};
    tbl[18] = '{'{1,0,11,0,1,5, 1,0,5,'h77,0},       '{1,0,0,0,0,1,1,0,0, 0,0,0, 1,1}};
    tbl[19] = '{'{1,0,0,0,0,0, 0,0,0,0,0},           '{1,0,0,0,0,0,0,0,0, 0,0,0, 1,1}};
    tbl[20] = '{'{1,11,11,0,0,0, 1,11,1,'h11,0},     '{1,0,0,1,'h11,0,0,1,'h11, 1,11,'h11, 0,1}};
    tbl[21] = '{'{0,0,0,0,0,0, 0,0,0,0,0},           '{0,0,0,0,0,0,0,0,0, 0,0,0, 0,1}};
    zero_e  = '{0,0,0,0,0,0,0,0,0, 0,0,0, 0,0};

    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", zero_e);

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset.issue_ready_first_cycle", 32'(issue_ready), 32'd0);

    for (int k = 0; k < NV; k++) begin
      drive(tbl[k].i);
      expq.push_back(tbl[k].e);
      @(posedge clk);
      #1;
      if (expq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL scoreboard_empty at vector %0d", k);
      end else begin
        check_all($sformatf("v%0d", k), expq.pop_front());
      end
      @(negedge clk);
    end

    // Mid-operation reset: pending lookup and regfile write must vanish.
    drive_idle();
    issue_valid = 1; issue_rd = 3; issue_rd_we = 1; issue_tag = 1;
    @(posedge clk);
    #1;
    chk("mid.busy_before_reset", 32'(busy_count), 32'd1);
    @(negedge clk);
    drive_idle();
    issue_valid = 1; issue_rs1 = 3; issue_rd = 4; issue_rd_we = 1; issue_tag = 2;
    commit_valid = 1; commit_rd = 3; commit_tag = 1; commit_data = 32'h33;
    #2;
    rst = 1'b1;
    #1;
    chk("mid.async_issue_ready", 32'(issue_ready), 32'd0);
    chk("mid.async_busy_count", 32'(busy_count), 32'd0);
    chk("mid.async_lk_valid", 32'(lk_valid), 32'd0);
    @(posedge clk);
    #1;
    check_all("mid.in_reset", zero_e);
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    #1;
    chk("mid.release_rf_we", 32'(rf_we), 32'd0);
    chk("mid.release_issue_ready", 32'(issue_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("mid.after_edge_rf_we", 32'(rf_we), 32'd0);
    chk("mid.after_edge_issue_ready", 32'(issue_ready), 32'd1);
    chk("mid.after_edge_busy_count", 32'(busy_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
